// File: rtl/io_port_bank.sv
// I/O bank behind the MMU I/O window: GPIO, a UART transmitter fed by a TX FIFO, and a
// compare timer with level IRQ that is built only when IO_TIMER_EN is defined.
module io_port_bank #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int FIFO_DEPTH_LOG = 4,
  parameter int GPIO_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              irq
);
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG;
  localparam int FDL    = FIFO_DEPTH_LOG;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [5:0] A_GPIO_OUT  = 6'h00;
  localparam logic [5:0] A_GPIO_IN   = 6'h01;
  localparam logic [5:0] A_UART_DATA = 6'h02;
  localparam logic [5:0] A_UART_STAT = 6'h03;
`ifdef IO_TIMER_EN
  localparam logic [5:0] A_TMR_COUNT = 6'h04;
  localparam logic [5:0] A_TMR_CMP   = 6'h05;
  localparam logic [5:0] A_TMR_CTRL  = 6'h06;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // io_en is a one-cycle valid with no back-pressure: reads answer in the same cycle,
  // writes commit at the closing edge.
  logic [5:0] word;
  logic       wr_en;
  logic       unused_bits;
  assign word        = io_addr[7:2];
  assign wr_en       = io_en && io_we;
  assign unused_bits = &{1'b0, io_addr[1:0], io_data_write};

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_en && word == A_GPIO_OUT) gpio_out_d = io_data_write[GPIO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end
  assign gpio_out = gpio_out_q;

  logic [FDL:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
  logic [7:0]   fifo_mem [DEPTH];
  logic         fifo_full, fifo_empty, push_req, push_ok, pop;
  logic         ovf_q, ovf_d;

  assign fifo_full  = (wr_ptr_q[FDL] != rd_ptr_q[FDL]) &&
                      (wr_ptr_q[FDL-1:0] == rd_ptr_q[FDL-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign push_req   = wr_en && word == A_UART_DATA;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && word == A_UART_STAT) ovf_d = 1'b0;
    else if (push_req && !push_ok)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[FDL-1:0]] <= io_data_write[7:0];
  end

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              baud_done, tx_busy;

  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = (state_q == S_IDLE) && !fifo_empty;
    tx_busy = (state_q != S_IDLE);
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // Baud counter restarts on every state entry and on every data-bit boundary.
  always_comb begin
    baud_d  = (state_q == S_IDLE || baud_done) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == S_START) bit_d = 3'd0;
    else if (state_q == S_DATA && baud_done) bit_d = bit_q + 3'd1;
    if (pop) shift_d = fifo_mem[rd_ptr_q[FDL-1:0]];
    else if (state_q == S_DATA && baud_done) shift_d = {1'b0, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] tmr_count_q, tmr_count_d, tmr_cmp_q, tmr_cmp_d;
  logic        tmr_en_q, tmr_en_d, tmr_pend_q, tmr_pend_d;

  // A CPU write to the count wins over the increment; a compare hit wins over a clear.
  always_comb begin
    tmr_count_d = tmr_count_q;
    tmr_cmp_d   = tmr_cmp_q;
    tmr_en_d    = tmr_en_q;
    tmr_pend_d  = tmr_pend_q;
    if (tmr_en_q) tmr_count_d = tmr_count_q + 32'd1;
    if (wr_en && word == A_TMR_COUNT) tmr_count_d = io_data_write;
    if (wr_en && word == A_TMR_CMP)   tmr_cmp_d   = io_data_write;
    if (wr_en && word == A_TMR_CTRL) begin
      tmr_en_d = io_data_write[0];
      if (io_data_write[1]) tmr_pend_d = 1'b0;
    end
    if (tmr_en_q && tmr_count_q == tmr_cmp_q) tmr_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_count_q <= '0;
      tmr_cmp_q   <= '0;
      tmr_en_q    <= 1'b0;
      tmr_pend_q  <= 1'b0;
    end else begin
      tmr_count_q <= tmr_count_d;
      tmr_cmp_q   <= tmr_cmp_d;
      tmr_en_q    <= tmr_en_d;
      tmr_pend_q  <= tmr_pend_d;
    end
  end
  assign irq = tmr_pend_q;
`else
  assign irq = 1'b0;
`endif

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (word)
      A_GPIO_OUT:  rd_val = 32'(gpio_out_q);
      A_GPIO_IN:   rd_val = 32'(sync2_q);
      A_UART_STAT: rd_val = {16'd0, 8'(fifo_count), 4'd0, ovf_q, tx_busy, fifo_empty, fifo_full};
`ifdef IO_TIMER_EN
      A_TMR_COUNT: rd_val = tmr_count_q;
      A_TMR_CMP:   rd_val = tmr_cmp_q;
      A_TMR_CTRL:  rd_val = {30'd0, tmr_pend_q, tmr_en_q};
`endif
      default:     rd_val = '0;
    endcase
  end

  assign io_data_read = (io_en && !io_we) ? rd_val : 32'd0;

endmodule
